// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: keypad HH:MM entry buffer with load strobes for time/alarm registers
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   key_valid, key[3:0]         one-cycle keypress strobe and key code
//   one_second                  one-cycle tick per second, drives the idle timeout
//   new_time_{ms,ls}_{hr,min}   4-digit entry buffer, hours tens first
//   load_new_c, load_new_a      one-cycle strobes: load buffer into time / alarm
//   entry_active                high while an entry is in progress
//   digit_count[2:0]            digits entered this entry, saturating at 4
//   entry_error                 one-cycle strobe: command rejected as invalid time
// Optional macro TIME_ENTRY_VALIDATE_EN: reject buffers that are not a valid 24h time.
module time_entry_ctrl #(
    parameter int         TIMEOUT_SEC   = 10,
    parameter logic [3:0] KEY_SET_TIME  = 4'hA,
    parameter logic [3:0] KEY_SET_ALARM = 4'hB,
    parameter logic [3:0] KEY_CLEAR     = 4'hC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       one_second,
    output logic [3:0] new_time_ms_hr,
    output logic [3:0] new_time_ls_hr,
    output logic [3:0] new_time_ms_min,
    output logic [3:0] new_time_ls_min,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       entry_active,
    output logic [2:0] digit_count,
    output logic       entry_error
);
    localparam int TW = $clog2(TIMEOUT_SEC + 1);
    typedef enum logic {IDLE, ENTRY} state_t;
    state_t        state, state_n;
    logic [15:0]   buf_q, buf_n;
    logic [2:0]    cnt_n;
    logic [TW-1:0] tmr, tmr_n;
    logic          ld_c_n, ld_a_n, valid, is_digit, is_set, is_clr;
`ifdef TIME_ENTRY_VALIDATE_EN
    logic          err_q, err_n;
    assign valid = (buf_q[15:12] <= 4'd2)
                && (buf_q[15:12] == 4'd2 ? buf_q[11:8] <= 4'd3 : buf_q[11:8] <= 4'd9)
                && (buf_q[7:4] <= 4'd5) && (buf_q[3:0] <= 4'd9);
    assign entry_error = err_q;
`else
    assign valid = 1'b1;
    assign entry_error = 1'b0;
`endif
    assign {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min} = buf_q;
    assign entry_active = (state == ENTRY);
    assign is_digit = key_valid && key <= 4'd9;
    assign is_set = key_valid && (key == KEY_SET_TIME || key == KEY_SET_ALARM);
    assign is_clr = key_valid && key == KEY_CLEAR;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            buf_q       <= '0;
            digit_count <= '0;
            tmr         <= '0;
            load_new_c  <= 1'b0;
            load_new_a  <= 1'b0;
`ifdef TIME_ENTRY_VALIDATE_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            buf_q       <= buf_n;
            digit_count <= cnt_n;
            tmr         <= tmr_n;
            load_new_c  <= ld_c_n;
            load_new_a  <= ld_a_n;
`ifdef TIME_ENTRY_VALIDATE_EN
            err_q       <= err_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        buf_n   = buf_q;
        cnt_n   = digit_count;
        tmr_n   = tmr;
        ld_c_n  = 1'b0;
        ld_a_n  = 1'b0;
`ifdef TIME_ENTRY_VALIDATE_EN
        err_n   = 1'b0;
`endif
        if (state == IDLE) begin
            if (is_digit) begin
                buf_n   = {12'd0, key};
                cnt_n   = 3'd1;
                tmr_n   = '0;
                state_n = ENTRY;
            end
        end else if (is_digit) begin
            buf_n = {buf_q[11:0], key};
            cnt_n = (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
            tmr_n = '0;
        end else if (is_clr) begin
            buf_n   = '0;
            cnt_n   = '0;
            tmr_n   = '0;
            state_n = IDLE;
        end else if (is_set) begin
            tmr_n = '0;
            if (valid) begin
                ld_c_n  = (key == KEY_SET_TIME);
                ld_a_n  = (key == KEY_SET_ALARM);
                cnt_n   = '0;
                state_n = IDLE;
            end
`ifdef TIME_ENTRY_VALIDATE_EN
            else err_n = 1'b1;
`endif
        end else if (one_second) begin
            // Last idle tick abandons the entry exactly like a clear key.
            if (tmr == TW'(TIMEOUT_SEC - 1)) begin
                buf_n   = '0;
                cnt_n   = '0;
                tmr_n   = '0;
                state_n = IDLE;
            end else begin
                tmr_n = tmr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb_time_entry_ctrl: directed table, corner sequences and random run against a spec-level model
module tb_time_entry_ctrl;
    localparam int T = 10;
    logic       clk = 1'b0, reset = 1'b1, key_valid = 1'b0, one_second = 1'b0;
    logic [3:0] key = 4'h0;
    logic [3:0] new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min;
    logic       load_new_c, load_new_a, entry_active, entry_error;
    logic [2:0] digit_count;
    int         n_cmp = 0, n_bad = 0;

    time_entry_ctrl #(.TIMEOUT_SEC(T)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key(key), .one_second(one_second),
        .new_time_ms_hr(new_time_ms_hr), .new_time_ls_hr(new_time_ls_hr),
        .new_time_ms_min(new_time_ms_min), .new_time_ls_min(new_time_ls_min),
        .load_new_c(load_new_c), .load_new_a(load_new_a), .entry_active(entry_active),
        .digit_count(digit_count), .entry_error(entry_error));

    always #5 clk = ~clk;

    logic [22:0] got;
    assign got = {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
                  load_new_c, load_new_a, entry_active, digit_count, entry_error};

    // Reference model: digits held as integers, time validity checked arithmetically.
    int md[4];
    int m_n, m_sec;
    bit m_act, m_c, m_a, m_err;

    function automatic bit time_ok();
`ifdef TIME_ENTRY_VALIDATE_EN
        return (md[0] * 10 + md[1] <= 23) && (md[2] * 10 + md[3] <= 59);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void m_clear();
        md = '{0, 0, 0, 0};
        m_act = 0; m_n = 0; m_sec = 0;
    endfunction

    function automatic void model_step(bit r, bit kv, int k, bit os);
        m_c = 0; m_a = 0; m_err = 0;
        if (r) m_clear();
        else if (kv && k <= 9) begin
            if (!m_act) begin md = '{0, 0, 0, k}; m_n = 1; m_act = 1; end
            else begin md = '{md[1], md[2], md[3], k}; m_n = (m_n < 4) ? m_n + 1 : 4; end
            m_sec = 0;
        end else if (kv && m_act && k == 12) m_clear();
        else if (kv && m_act && (k == 10 || k == 11)) begin
            m_sec = 0;
            if (time_ok()) begin m_c = (k == 10); m_a = (k == 11); m_act = 0; m_n = 0; end
            else m_err = 1;
        end else if (m_act && os) begin
            m_sec++;
            if (m_sec == T) m_clear();
        end
    endfunction

    function automatic logic [22:0] m_exp();
        return {md[0][3:0], md[1][3:0], md[2][3:0], md[3][3:0], m_c, m_a, m_act, m_n[2:0], m_err};
    endfunction

    task automatic chk(input string name, input logic [22:0] a, input logic [22:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    task automatic tick(input bit r, input bit kv, input logic [3:0] k, input bit os);
        reset = r; key_valid = kv; key = k; one_second = os;
        model_step(r, kv, int'(k), os);
        @(posedge clk);
        #1;
        chk("model", got, m_exp());
    endtask

    typedef struct packed {
        bit r; bit kv; logic [3:0] k; bit os;
        logic [15:0] b; bit c; bit a; bit act; logic [2:0] n; bit err;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit r, bit kv, logic [3:0] k, bit os, logic [15:0] b,
                               bit c, bit a, bit act, logic [2:0] n);
        return {r, kv, k, os, b, c, a, act, n, 1'b0};
    endfunction

    initial begin
        tbl.push_back(v(1, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'h1, 0, 16'h0001, 0, 0, 1, 3'd1));
        tbl.push_back(v(0, 1, 4'h2, 0, 16'h0012, 0, 0, 1, 3'd2));
        tbl.push_back(v(0, 1, 4'h3, 0, 16'h0123, 0, 0, 1, 3'd3));
        tbl.push_back(v(0, 1, 4'h4, 0, 16'h1234, 0, 0, 1, 3'd4));
        tbl.push_back(v(0, 1, 4'hA, 0, 16'h1234, 1, 0, 0, 3'd0));
        tbl.push_back(v(0, 0, 4'h0, 0, 16'h1234, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'h9, 0, 16'h0009, 0, 0, 1, 3'd1));
        tbl.push_back(v(0, 1, 4'h1, 0, 16'h0091, 0, 0, 1, 3'd2));
        tbl.push_back(v(0, 1, 4'h5, 0, 16'h0915, 0, 0, 1, 3'd3));
        tbl.push_back(v(0, 1, 4'h2, 0, 16'h9152, 0, 0, 1, 3'd4));
        tbl.push_back(v(0, 1, 4'h7, 0, 16'h1527, 0, 0, 1, 3'd4));
        tbl.push_back(v(0, 1, 4'hB, 0, 16'h1527, 0, 1, 0, 3'd0));
        tbl.push_back(v(0, 0, 4'h0, 0, 16'h1527, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'hA, 0, 16'h1527, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'hB, 1, 16'h1527, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'hC, 0, 16'h1527, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'hE, 0, 16'h1527, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'hF, 0, 16'h1527, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'h7, 0, 16'h0007, 0, 0, 1, 3'd1));
        tbl.push_back(v(0, 1, 4'h3, 0, 16'h0073, 0, 0, 1, 3'd2));
        tbl.push_back(v(0, 1, 4'h0, 0, 16'h0730, 0, 0, 1, 3'd3));
        tbl.push_back(v(0, 1, 4'hD, 1, 16'h0730, 0, 0, 1, 3'd3));
        tbl.push_back(v(0, 1, 4'hC, 0, 16'h0000, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'h0, 0, 16'h0000, 0, 0, 1, 3'd1));
        tbl.push_back(v(0, 1, 4'h8, 0, 16'h0008, 0, 0, 1, 3'd2));
        tbl.push_back(v(1, 1, 4'hA, 0, 16'h0000, 0, 0, 0, 3'd0));
        tbl.push_back(v(0, 1, 4'h0, 0, 16'h0000, 0, 0, 1, 3'd1));
        tbl.push_back(v(0, 1, 4'h8, 0, 16'h0008, 0, 0, 1, 3'd2));
        tbl.push_back(v(0, 1, 4'hA, 0, 16'h0008, 1, 0, 0, 3'd0));
        tbl.push_back(v(1, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 3'd0));
        m_clear();
        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].kv, tbl[i].k, tbl[i].os);
            chk("table", got, {tbl[i].b, tbl[i].c, tbl[i].a, tbl[i].act, tbl[i].n, tbl[i].err});
        end

        // Idle timeout: abandoned exactly on tick T.
        tick(0, 1, 4'h5, 0);
        for (int i = 0; i < T - 1; i++) tick(0, 0, 4'h0, 1);
        chk("timeout_pre", 23'(entry_active), 23'd1);
        tick(0, 0, 4'h0, 1);
        chk("timeout_idle", {19'd0, entry_active, digit_count}, 23'd0);
        chk("timeout_buf", 23'(got[22:7]), 23'd0);

        // Key on tick T-1 restarts the count; D keys do not.
        tick(0, 1, 4'h5, 0);
        for (int i = 0; i < T - 2; i++) tick(0, 0, 4'h0, 1);
        tick(0, 1, 4'h6, 1);
        tick(0, 0, 4'h0, 1);
        chk("timeout_restart", {19'd0, entry_active, digit_count}, {19'd0, 1'b1, 3'd2});
        for (int i = 0; i < T - 2; i++) tick(0, 1, 4'hD, 1);
        chk("timeout_d_pre", 23'(entry_active), 23'd1);
        tick(0, 1, 4'hE, 1);
        chk("timeout_d_idle", 23'(entry_active), 23'd0);

        // 24:00 is rejected only when validation is built.
        tick(1, 0, 4'h0, 0);
        tick(0, 1, 4'h2, 0);
        tick(0, 1, 4'h4, 0);
        tick(0, 1, 4'h0, 0);
        tick(0, 1, 4'h0, 0);
        tick(0, 1, 4'hA, 0);
`ifdef TIME_ENTRY_VALIDATE_EN
        chk("invalid_err", {20'd0, entry_error, load_new_c, entry_active}, 23'b111 & 23'b101);
        tick(0, 0, 4'h0, 0);
        chk("invalid_err_end", {21'd0, entry_error, entry_active}, 23'b01);
        tick(0, 1, 4'hC, 0);
        chk("invalid_clear", {got[22:7], entry_active}, 23'd0);
`else
        chk("accept_2400", {20'd0, entry_error, load_new_c, entry_active}, 23'b010);
        chk("accept_buf", 23'(got[22:7]), 23'h2400);
`endif

        // Random stimulus against the model.
        tick(1, 0, 4'h0, 0);
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
